display_timing_recovery: RTL and testbench

DISPLAY_TIMING_RECOVERY -- requirements
Module: display_timing_recovery

---
 rtl/display_timing_recovery.sv | 195 +++++++++++++++++++
 tb/tb_display_timing_recovery.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_recovery.sv
// Recovers active-area coordinates and frame geometry from a DE/HSYNC/VSYNC pixel stream.
// A frame is the interval between two vsync falling edges; lock requires LOCK_FRAMES matching frames.
//
// state   | meaning
// SEEK    | waiting for the first vsync falling edge after reset
// MEASURE | comparing frames, counting consecutive consistent ones
// LOCKED  | geometry latched into meas_*, every line and frame checked against it
module display_timing_recovery #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pix_clk,
  input  logic        rst_pix,
  input  logic        de,
  input  logic        n_hsync,
  input  logic        n_vsync,
  output logic        pix_valid,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] meas_width,
  output logic [15:0] meas_height,
  output logic [15:0] meas_htotal,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [1:0] SEEK    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  logic [1:0]  state;
  logic        de_q, hs_q, vs_q;
  logic        frame_pend;
  logic        hs_seen;
  logic [15:0] hs_cnt;
  logic [15:0] line_cnt;
  logic [15:0] ref_width;
  logic        ref_valid;
  logic        lines_ok;
  logic [15:0] prev_width;
  logic [15:0] prev_height;
  logic        prev_valid;
  logic [3:0]  good_cnt;

  logic        vs_evt, hs_evt, de_rise, de_fall;
  logic        sync_err, width_bad, height_bad;
  logic        frame_clean, frame_good;
  logic [15:0] line_width;
  logic [3:0]  good_inc;

  assign vs_evt     = vs_q & ~n_vsync;
  assign hs_evt     = hs_q & ~n_hsync;
  assign de_rise    = de & ~de_q;
  assign de_fall    = ~de & de_q;
  assign line_width = (ax == 16'hFFFF) ? ax : ax + 16'd1;
  assign sync_err   = de & ~n_vsync;
  assign width_bad  = (state == LOCKED) && de_fall && (line_width != meas_width);
  assign height_bad = (state == LOCKED) && vs_evt && (line_cnt != meas_height);
  // A frame is internally clean when it had lines and all of them matched its first line.
  assign frame_clean = lines_ok && ref_valid && (line_cnt != 16'd0);
  assign frame_good  = frame_clean &&
                       (!prev_valid || ((ref_width == prev_width) && (line_cnt == prev_height)));
  assign good_inc    = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;

  always_ff @(posedge pix_clk) begin
    if (rst_pix) begin
      state       <= SEEK;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      frame_pend  <= 1'b0;
      hs_seen     <= 1'b0;
      hs_cnt      <= '0;
      line_cnt    <= '0;
      ref_width   <= '0;
      ref_valid   <= 1'b0;
      lines_ok    <= 1'b0;
      prev_width  <= '0;
      prev_height <= '0;
      prev_valid  <= 1'b0;
      good_cnt    <= '0;
      pix_valid   <= 1'b0;
      ax          <= '0;
      ay          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      meas_htotal <= '0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      de_q <= de;
      hs_q <= n_hsync;
      vs_q <= n_vsync;

      pix_valid   <= de;
      line_start  <= de_rise;
      frame_start <= de_rise & (frame_pend | vs_evt);

      if (de_rise) begin
        ax <= '0;
      end else if (de && de_q && (ax != 16'hFFFF)) begin
        ax <= ax + 16'd1;
      end

      // vsync coinciding with the first de of a line still makes that line row 0
      if (de_rise) begin
        frame_pend <= 1'b0;
        if (frame_pend || vs_evt) begin
          ay <= '0;
        end else if (ay != 16'hFFFF) begin
          ay <= ay + 16'd1;
        end
      end else if (vs_evt) begin
        frame_pend <= 1'b1;
      end

      if (hs_evt) begin
        hs_seen <= 1'b1;
        hs_cnt  <= 16'd1;
        if (hs_seen) begin
          meas_htotal <= hs_cnt;
        end
      end else if (hs_seen && (hs_cnt != 16'hFFFF)) begin
        hs_cnt <= hs_cnt + 16'd1;
      end

      if (vs_evt) begin
        ref_valid <= 1'b0;
        lines_ok  <= 1'b1;
        line_cnt  <= {15'd0, de_rise};
      end else begin
        if (de_rise && (line_cnt != 16'hFFFF)) begin
          line_cnt <= line_cnt + 16'd1;
        end
        if (de_fall) begin
          if (!ref_valid) begin
            ref_width <= line_width;
            ref_valid <= 1'b1;
          end else if (line_width != ref_width) begin
            lines_ok <= 1'b0;
          end
        end
      end

      if (sync_err || width_bad || height_bad) begin
        timing_err <= 1'b1;
      end

      case (state)
        SEEK: begin
          if (vs_evt) begin
            state      <= MEASURE;
            good_cnt   <= '0;
            prev_valid <= 1'b0;
          end
        end
        MEASURE: begin
          if (vs_evt) begin
            prev_width  <= ref_width;
            prev_height <= line_cnt;
            prev_valid  <= frame_clean;
            if (frame_good) begin
              good_cnt <= good_inc;
              if (good_inc >= LOCK_N) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                meas_width  <= ref_width;
                meas_height <= line_cnt;
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (sync_err || width_bad || height_bad) begin
            state      <= MEASURE;
            locked     <= 1'b0;
            good_cnt   <= '0;
            prev_valid <= 1'b0;
          end
        end
        default: begin
          state  <= SEEK;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_timing_recovery.sv
// Bench for display_timing_recovery: 8x4 active area, htotal 12, vtotal 7, LOCK_FRAMES = 2.
// A reference model pushes expected per-pixel outputs; a monitor pops them one cycle later.
module tb_display_timing_recovery;

  logic        pix_clk = 1'b0;
  logic        rst_pix = 1'b1;
  logic        de = 1'b0;
  logic        n_hsync = 1'b1;
  logic        n_vsync = 1'b1;
  logic        pix_valid;
  logic [15:0] ax, ay;
  logic        line_start, frame_start;
  logic [15:0] meas_width, meas_height, meas_htotal;
  logic        locked, timing_err;

  display_timing_recovery #(.LOCK_FRAMES(2)) dut (
    .pix_clk(pix_clk), .rst_pix(rst_pix), .de(de), .n_hsync(n_hsync), .n_vsync(n_vsync),
    .pix_valid(pix_valid), .ax(ax), .ay(ay), .line_start(line_start), .frame_start(frame_start),
    .meas_width(meas_width), .meas_height(meas_height), .meas_htotal(meas_htotal),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 pix_clk = ~pix_clk;

  typedef struct packed {
    logic        pv;
    logic        ls;
    logic        fs;
    logic        chk_xy;
    logic [15:0] ax;
    logic [15:0] ay;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state (spec behaviour of the coordinate path)
  logic        m_de = 1'b0, m_vs = 1'b0, m_pend = 1'b0;
  logic [15:0] m_ax = '0, m_ay = '0;

  // per-frame observations from the monitor
  int          fs_cnt, ls_cnt;
  logic [15:0] ax_max, ay_max, ay_at_fs;

  // snapshots around a probe point inside a frame
  logic        snap_a_lk, snap_a_err, snap_b_lk, snap_b_err;
  logic [47:0] snap_b_meas;

  task automatic drive(input logic r, input logic d, input logic hs, input logic vs);
    exp_t e;
    logic vse, dr;
    @(negedge pix_clk);
    rst_pix = r; de = d; n_hsync = hs; n_vsync = vs;
    if (r) begin
      e = '0;
      e.chk_xy = 1'b1;
      m_de = 1'b0; m_vs = 1'b0; m_pend = 1'b0; m_ax = '0; m_ay = '0;
    end else begin
      vse = m_vs & ~vs;
      dr  = d & ~m_de;
      e.pv = d; e.ls = dr; e.fs = dr & (m_pend | vse); e.chk_xy = d;
      if (dr) m_ax = '0;
      else if (d && m_de && m_ax != 16'hFFFF) m_ax = m_ax + 16'd1;
      if (dr) begin
        if (m_pend || vse) m_ay = '0;
        else if (m_ay != 16'hFFFF) m_ay = m_ay + 16'd1;
        m_pend = 1'b0;
      end else if (vse) begin
        m_pend = 1'b1;
      end
      e.ax = m_ax; e.ay = m_ay;
      m_de = d; m_vs = vs;
    end
    exp_q.push_back(e);
  endtask

  always @(posedge pix_clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if ({pix_valid, line_start, frame_start} !== {mon_e.pv, mon_e.ls, mon_e.fs}) begin
        n_errors++;
        $display("FAIL strobes @%0t: pv/ls/fs got %b%b%b expected %b%b%b", $time,
                 pix_valid, line_start, frame_start, mon_e.pv, mon_e.ls, mon_e.fs);
      end
      if (mon_e.chk_xy) begin
        n_checks++;
        if (ax !== mon_e.ax || ay !== mon_e.ay) begin
          n_errors++;
          $display("FAIL coords @%0t: ax/ay got %0d/%0d expected %0d/%0d", $time,
                   ax, ay, mon_e.ax, mon_e.ay);
        end
      end
      if (frame_start) begin fs_cnt++; ay_at_fs = ay; end
      if (line_start) ls_cnt++;
      if (pix_valid && ax > ax_max) ax_max = ax;
      if (pix_valid && ay > ay_max) ay_max = ay;
    end
  end

  // One 12x7 frame; vsync falls at its first cycle unless coinc moves it onto the first de.
  task automatic run_frame(input int short_row, input bit sync_pulse, input bit coinc,
                           input int rst_line, input int probe_line, input int probe_col);
    logic d, hs, vs, r;
    fs_cnt = 0; ls_cnt = 0; ax_max = '0; ay_max = '0; ay_at_fs = 16'hFFFF;
    for (int line = 0; line < 7; line++) begin
      for (int col = 0; col < 12; col++) begin
        vs = coinc ? !(line == 2 && col == 3) : (line != 0);
        hs = (col >= 2);
        d  = (line >= 2 && line <= 5 && col >= 3 && col <= 10);
        if (line - 2 == short_row && col == 10) d = 1'b0;
        if (sync_pulse && line == 0 && col == 5) d = 1'b1;
        r  = (line == rst_line && col == 6);
        drive(r, d, hs, vs);
        if (line == probe_line && col == probe_col) begin
          snap_a_lk = locked; snap_a_err = timing_err;
        end
        if (line == probe_line && col == probe_col + 1) begin
          snap_b_lk = locked; snap_b_err = timing_err;
          snap_b_meas = {meas_width, meas_height, meas_htotal};
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (locked !== 1'b0 || timing_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: locked/err got %b%b expected 00", locked, timing_err);
    end
    n_checks++;
    if ({meas_width, meas_height, meas_htotal} !== 48'd0) begin
      n_errors++;
      $display("FAIL reset_meas: got %0d/%0d/%0d expected 0/0/0", meas_width, meas_height, meas_htotal);
    end
  endtask

  task automatic test_lock_acquire();
    run_frame(-1, 0, 0, -1, -1, -1);
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_early: locked got %b expected 0 before third vsync", locked);
    end
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b1 || timing_err !== 1'b0) begin
      n_errors++;
      $display("FAIL lock_acquire: locked/err got %b%b expected 10", locked, timing_err);
    end
    n_checks++;
    if (meas_width !== 16'd8 || meas_height !== 16'd4 || meas_htotal !== 16'd12) begin
      n_errors++;
      $display("FAIL lock_meas: got %0d/%0d/%0d expected 8/4/12", meas_width, meas_height, meas_htotal);
    end
  endtask

  task automatic test_frame_scan();
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (fs_cnt !== 1 || ls_cnt !== 4) begin
      n_errors++;
      $display("FAIL scan_pulses: frame_start/line_start got %0d/%0d expected 1/4", fs_cnt, ls_cnt);
    end
    n_checks++;
    if (ax_max !== 16'd7 || ay_max !== 16'd3 || ay_at_fs !== 16'd0) begin
      n_errors++;
      $display("FAIL scan_range: ax_max/ay_max/ay@fs got %0d/%0d/%0d expected 7/3/0", ax_max, ay_max, ay_at_fs);
    end
  endtask

  task automatic test_short_line();
    run_frame(1, 0, 0, -1, 3, 10);
    n_checks++;
    if (snap_a_lk !== 1'b1 || snap_a_err !== 1'b0) begin
      n_errors++;
      $display("FAIL short_before: locked/err got %b%b expected 10", snap_a_lk, snap_a_err);
    end
    n_checks++;
    if (snap_b_lk !== 1'b0 || snap_b_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_after: locked/err got %b%b expected 01", snap_b_lk, snap_b_err);
    end
    run_frame(-1, 0, 0, -1, -1, -1);
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL short_relock_early: locked got %b expected 0", locked);
    end
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b1 || timing_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_relock: locked/err got %b%b expected 11", locked, timing_err);
    end
  endtask

  task automatic test_sync_violation();
    run_frame(-1, 1, 0, -1, 0, 5);
    n_checks++;
    if (snap_a_lk !== 1'b1) begin
      n_errors++;
      $display("FAIL sync_before: locked got %b expected 1", snap_a_lk);
    end
    n_checks++;
    if (snap_b_lk !== 1'b0 || snap_b_err !== 1'b1) begin
      n_errors++;
      $display("FAIL sync_after: locked/err got %b%b expected 01", snap_b_lk, snap_b_err);
    end
    for (int i = 0; i < 3; i++) run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL sync_relock: locked got %b expected 1", locked);
    end
  endtask

  task automatic test_coincident();
    run_frame(-1, 0, 1, -1, -1, -1);
    n_checks++;
    if (fs_cnt !== 1 || ay_at_fs !== 16'd0 || ay_max !== 16'd3 || ls_cnt !== 4) begin
      n_errors++;
      $display("FAIL coincident: fs/ay@fs/ay_max/ls got %0d/%0d/%0d/%0d expected 1/0/3/4",
               fs_cnt, ay_at_fs, ay_max, ls_cnt);
    end
    for (int i = 0; i < 3; i++) run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL coinc_relock: locked got %b expected 1", locked);
    end
  endtask

  task automatic test_reset_mid_line();
    run_frame(-1, 0, 0, 3, 3, 6);
    n_checks++;
    if (snap_a_lk !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_before: locked got %b expected 1", snap_a_lk);
    end
    n_checks++;
    if (snap_b_lk !== 1'b0 || snap_b_err !== 1'b0 || snap_b_meas !== 48'd0) begin
      n_errors++;
      $display("FAIL rst_after: locked/err got %b%b meas %h expected 00 and 0", snap_b_lk, snap_b_err, snap_b_meas);
    end
    run_frame(-1, 0, 0, -1, -1, -1);
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_relock_early: locked got %b expected 0", locked);
    end
    run_frame(-1, 0, 0, -1, -1, -1);
    n_checks++;
    if (locked !== 1'b1 || timing_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_relock: locked/err got %b%b expected 10", locked, timing_err);
    end
    n_checks++;
    if (meas_width !== 16'd8 || meas_height !== 16'd4 || meas_htotal !== 16'd12) begin
      n_errors++;
      $display("FAIL rst_meas: got %0d/%0d/%0d expected 8/4/12", meas_width, meas_height, meas_htotal);
    end
  endtask

  initial begin
    test_reset();
    test_lock_acquire();
    test_frame_scan();
    test_short_line();
    test_sync_violation();
    test_coincident();
    test_reset_mid_line();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge pix_clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
